m_bcd_cnt: RTL
==============

Name: m_bcd_cnt

Overview:
- Parametrised two-digit BCD counter for the digital clock datapath.
- Generalises the fixed modulo-60 seconds/minutes counter:
  - programmable MIN_VAL..MAX_VAL range, so one block covers 0-59, 0-23 and 1-12;
  - count enable;
  - up/down direction;
  - synchronous parallel load for time setting;
  - registered carry/borrow pulse for chaining to the next stage.
- Instantiated once per time field (sec, min, hour); the co of one stage drives the en of the next.

Parameters:
- MAX_VAL, 59, upper bound of the count (decimal, 1..99, > MIN_VAL).
- MIN_VAL, 0, lower bound of the count and the reset value (decimal, 0..98).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- en, input, 1, count enable: one step per clk while high.
- up, input, 1, direction: 1 = increment, 0 = decrement.
- load, input, 1, synchronous load strobe.
- ld_ql, input, 4, BCD units digit to load.
- ld_qh, input, 4, BCD tens digit to load.
- ql, output, 4, BCD units digit of the count.
- qh, output, 4, BCD tens digit of the count.
- co, output, 1, carry/borrow pulse, registered.

Behaviour:
- Value V = 10*qh + ql. V always satisfies MIN_VAL <= V <= MAX_VAL, and each digit is always 0..9.
- Reset (rst=0, asynchronous):
  - ql = MIN_VAL%10, qh = MIN_VAL/10, co = 0.
  - Takes effect immediately, including mid-count or mid-load.
- Release: first count step on the first rising edge with rst=1 and en=1.
- Per-edge priority is load > en > hold.
- Load (load=1):
  - If ld_ql<=9, ld_qh<=9 and MIN_VAL <= 10*ld_qh+ld_ql <= MAX_VAL, then V takes the loaded value.
  - Otherwise V = MIN_VAL.
  - co = 0 during a load. en is ignored in that cycle.
- Count up (load=0, en=1, up=1):
  - V<MAX_VAL:
    - If ql<9, ql+1.
    - If ql==9, ql=0 and qh+1.
    - co = 0.
  - V==MAX_VAL: V = MIN_VAL, co = 1.
- Count down (load=0, en=1, up=0):
  - V>MIN_VAL:
    - If ql>0, ql-1.
    - If ql==0, ql=9 and qh-1.
    - co = 0.
  - V==MIN_VAL: V = MAX_VAL, co = 1.
- Hold (load=0, en=0): V unchanged, co = 0.
- co timing:
  - co is high for exactly one clk, in the same cycle the wrapped value first appears on ql/qh (1-cycle latency from the wrapping edge).
  - Consecutive wraps with MAX_VAL-MIN_VAL = 0 are disallowed by parameter range.
- Direction change takes effect on the next enabled edge. There is no hysteresis.
- Digit arithmetic is 4-bit BCD. Binary values 10..15 are never produced.

Optional Feature:
- Macro: M_BCD_CNT_CLR_EN.
- Defined:
  - Adds input clr (1 bit), a synchronous clear with top priority over load and en.
  - When clr=1, V = MIN_VAL and co = 0 on the next edge.
- Undefined:
  - Port clr is absent.
  - Behaviour is exactly as above.

Test Plan:
- MAX_VAL=59, MIN_VAL=0: reset, then en=1, up=1 for 60 clocks -> ql/qh step 00..59 then 00; co=1 only in the cycle showing 00 after 59.
- MAX_VAL=12, MIN_VAL=1: reset -> qh=0, ql=1; count up 12 steps -> sequence 02..12, then 01 with co=1; 09->10 rolls ql to 0 and qh to 1.
- MAX_VAL=23: load with ld_qh=2, ld_ql=3, then en=1, up=1 -> value 23, then 00 with co=1. Load 2,4 (out of range) -> 00. Load ld_ql=4'hA -> 00.
- MAX_VAL=59: at V=00 apply up=0, en=1 -> 59 with co=1, then 58; at V=10, down -> 09.
- Assert rst low mid-count at V=37 between edges -> outputs go to 00 and co=0 immediately. load=1 and en=1 together at V=05 -> loaded value wins, no increment.
- With M_BCD_CNT_CLR_EN: clr=1, load=1, en=1 at V=42 -> V=MIN_VAL, co=0. Without the macro, the build has no clr port.

Source files
------------

// File: rtl/m_bcd_cnt_if.sv
// Control/data bundle for one m_bcd_cnt stage: count controls, load digits, BCD outputs, carry.
// The optional synchronous clear (macro M_BCD_CNT_CLR_EN) adds the clr member.
interface m_bcd_cnt_if;
`ifdef M_BCD_CNT_CLR_EN
  logic       clr;
`endif
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] ld_ql;
  logic [3:0] ld_qh;
  logic [3:0] ql;
  logic [3:0] qh;
  logic       co;

  modport master (
`ifdef M_BCD_CNT_CLR_EN
    output clr,
`endif
    output en, up, load, ld_ql, ld_qh,
    input  ql, qh, co
  );

  modport slave (
`ifdef M_BCD_CNT_CLR_EN
    input  clr,
`endif
    input  en, up, load, ld_ql, ld_qh,
    output ql, qh, co
  );
endinterface

// File: rtl/m_bcd_cnt.sv
// Two-digit BCD up/down counter over MIN_VAL..MAX_VAL with load and a registered wrap pulse.
// Optional synchronous clear with top priority when M_BCD_CNT_CLR_EN is defined.
module m_bcd_cnt #(
  parameter int unsigned MAX_VAL = 59,
  parameter int unsigned MIN_VAL = 0
) (
  input logic        clk,
  input logic        rst,
  m_bcd_cnt_if.slave bus
);

  localparam logic [3:0] MAX_L = 4'(MAX_VAL % 10);
  localparam logic [3:0] MAX_H = 4'(MAX_VAL / 10);
  localparam logic [3:0] MIN_L = 4'(MIN_VAL % 10);
  localparam logic [3:0] MIN_H = 4'(MIN_VAL / 10);
  localparam logic [7:0] MIN_B = 8'(MIN_VAL);
  localparam logic [7:0] SPAN  = 8'(MAX_VAL - MIN_VAL);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN,
    OP_CLR
  } op_e;

  op_e        op;
  logic [3:0] ql_q, ql_d;
  logic [3:0] qh_q, qh_d;
  logic       co_q, co_d;
  logic       at_max, at_min;
  logic       ld_ok;
  logic [7:0] ld_val;

  assign at_max = (qh_q == MAX_H) && (ql_q == MAX_L);
  assign at_min = (qh_q == MIN_H) && (ql_q == MIN_L);
  assign ld_val = 8'(bus.ld_qh) * 8'd10 + 8'(bus.ld_ql);

  // Modular offset from MIN: a value below MIN wraps far above SPAN, so one compare covers both bounds.
  assign ld_ok = (bus.ld_ql <= 4'd9) && (bus.ld_qh <= 4'd9) &&
                 ((ld_val - MIN_B) <= SPAN);

  always_comb begin
    if (bus.load)    op = OP_LOAD;
    else if (bus.en) op = bus.up ? OP_UP : OP_DOWN;
    else             op = OP_HOLD;
`ifdef M_BCD_CNT_CLR_EN
    if (bus.clr)     op = OP_CLR;
`endif
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    ql_d = ql_q;
    qh_d = qh_q;
    co_d = 1'b0;
    case (op)
      OP_CLR: begin
        ql_d = MIN_L;
        qh_d = MIN_H;
      end
      OP_LOAD: begin
        ql_d = ld_ok ? bus.ld_ql : MIN_L;
        qh_d = ld_ok ? bus.ld_qh : MIN_H;
      end
      OP_UP: begin
        if (at_max) begin
          ql_d = MIN_L;
          qh_d = MIN_H;
          co_d = 1'b1;
        end else if (ql_q == 4'd9) begin
          ql_d = 4'd0;
          qh_d = qh_q + 4'd1;
        end else begin
          ql_d = ql_q + 4'd1;
        end
      end
      OP_DOWN: begin
        if (at_min) begin
          ql_d = MAX_L;
          qh_d = MAX_H;
          co_d = 1'b1;
        end else if (ql_q == 4'd0) begin
          ql_d = 4'd9;
          qh_d = qh_q - 4'd1;
        end else begin
          ql_d = ql_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  // co is registered alongside the digits, so it coincides with the wrapped value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      ql_q <= MIN_L;
      qh_q <= MIN_H;
      co_q <= 1'b0;
    end else begin
      ql_q <= ql_d;
      qh_q <= qh_d;
      co_q <= co_d;
    end
  end

  assign bus.ql = ql_q;
  assign bus.qh = qh_q;
  assign bus.co = co_q;

endmodule
